// File: rtl/coffee_pkg.sv
// Shared types and helpers for the coffee order controller: state encoding,
// drink indices, prices and coin/button qualification.
package coffee_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAY,
    ST_DISPENSE,
    ST_CHANGE,
    ST_ERROR
  } state_t;

  localparam int DRINK_CE01 = 0;
  localparam int DRINK_CL02 = 1;
  localparam int DRINK_CC05 = 2;
  localparam int DRINK_CP10 = 3;

  localparam logic [3:0] PRICE_CE01 = 4'd1;
  localparam logic [3:0] PRICE_CL02 = 4'd2;
  localparam logic [3:0] PRICE_CC05 = 4'd5;
  localparam logic [3:0] PRICE_CP10 = 4'd10;

  function automatic logic coin_legal(input logic [3:0] val);
    return (val == 4'd1) || (val == 4'd2) || (val == 4'd5) || (val == 4'd10);
  endfunction

  function automatic logic one_hot4(input logic [3:0] val);
    return (val != 4'd0) && ((val & (val - 4'd1)) == 4'd0);
  endfunction

  // Selection is one-hot while it matters; an empty selection prices at 0.
  function automatic logic [3:0] price_of(input logic [3:0] sel);
    logic [3:0] price;
    price = 4'd0;
    if (sel[DRINK_CE01]) price = PRICE_CE01;
    else if (sel[DRINK_CL02]) price = PRICE_CL02;
    else if (sel[DRINK_CC05]) price = PRICE_CC05;
    else if (sel[DRINK_CP10]) price = PRICE_CP10;
    return price;
  endfunction

endpackage

// File: rtl/coffee_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module coffee_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/coffee_order_controller.sv
// Order sequencer: drink selection, coin credit, dispense strobe, change/refund
// and the registered status flags consumed by the seven-segment decoder.
//
// state       | meaning
// ST_IDLE     | waiting for a single drink button
// ST_PAY      | accumulating coins, timeout running
// ST_DISPENSE | dispense strobe high for DISP_CYCLES
// ST_CHANGE   | one cycle after change pulse; clears credit and selection
// ST_ERROR    | sensor fault, held ERR_HOLD cycles and until sensors clear
module coffee_order_controller
  import coffee_pkg::*;
#(
  parameter int CREDIT_W    = 5,
  parameter int DISP_CYCLES = 8,
  parameter int PAY_TIMEOUT = 64,
  parameter int ERR_HOLD    = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [3:0]          BTN,
  input  logic                CANCEL,
  input  logic                COIN_VALID,
  input  logic [3:0]          COIN_VAL,
  input  logic                SR_IN,
  input  logic                SP_IN,
  input  logic                SN_IN,
  output logic                S0,
  output logic                S1,
  output logic                S2,
  output logic                S3,
  output logic                ESR,
  output logic                ESP,
  output logic                ESN,
  output logic                VL,
  output logic                M,
  output logic                DISPENSE,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic [CREDIT_W-1:0] CHANGE,
  output logic                CHANGE_VLD
);

  localparam int PAY_W  = $clog2(PAY_TIMEOUT + 1);
  localparam int DISP_W = $clog2(DISP_CYCLES + 1);
  localparam int HOLD_W = $clog2(ERR_HOLD + 1);

  state_t              state_q, state_n;
  logic [3:0]          sel_q, sel_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic [CREDIT_W-1:0] change_q, change_n;
  logic                change_vld_q, change_vld_n;
  logic                dispense_q, dispense_n;
  logic                vl_q, vl_n;
  logic [2:0]          es_q, es_n;
  logic                m_q, m_n;

  logic                pay_load, disp_load, hold_load;
  logic                pay_done, disp_done, hold_done;
  logic                go_err, coin_taken;
  logic [2:0]          sensors;
  logic                fault;
  logic [CREDIT_W:0]   coin_sum, price_ext, amt;
  logic [CREDIT_W-1:0] base;

  assign sensors   = {SR_IN, SP_IN, SN_IN};
  assign fault     = |sensors;
  assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(COIN_VAL);
  assign price_ext = (CREDIT_W+1)'(price_of(sel_q));

  always_comb begin
    state_n    = state_q;
    sel_n      = sel_q;
    credit_n   = credit_q;
    es_n       = es_q;
    base       = '0;
    dispense_n = 1'b0;
    vl_n       = vl_q && !hold_done;
    pay_load   = 1'b0;
    disp_load  = 1'b0;
    hold_load  = 1'b0;
    go_err     = 1'b0;
    coin_taken = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (one_hot4(BTN)) begin
          if (fault) go_err = 1'b1;
          else begin
            state_n  = ST_PAY;
            sel_n    = BTN;
            pay_load = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (fault) go_err = 1'b1;
        else if (CANCEL) begin
          state_n = ST_CHANGE;
          base    = credit_q;
        end else if (COIN_VALID) begin
          pay_load = 1'b1;
          if (coin_legal(COIN_VAL)) begin
            coin_taken = 1'b1;
            credit_n   = coin_sum[CREDIT_W-1:0];
            if (coin_sum >= price_ext) begin
              state_n    = ST_DISPENSE;
              dispense_n = 1'b1;
              disp_load  = 1'b1;
            end
          end else begin
            vl_n      = 1'b1;
            hold_load = 1'b1;
          end
        end else if (pay_done) begin
          vl_n      = 1'b1;
          hold_load = 1'b1;
          state_n   = ST_CHANGE;
          base      = credit_q;
        end
      end
      ST_DISPENSE: begin
        if (fault) go_err = 1'b1;
        else if (disp_done) begin
          state_n = ST_CHANGE;
          base    = credit_q - price_ext[CREDIT_W-1:0];
        end else dispense_n = 1'b1;
      end
      ST_CHANGE: begin
        state_n  = ST_IDLE;
        credit_n = '0;
        sel_n    = '0;
      end
      ST_ERROR: begin
        es_n = es_q | sensors;
        if (hold_done && !fault) begin
          state_n = ST_IDLE;
          es_n    = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Fault abort: drop everything, refund whatever credit was collected.
    if (go_err) begin
      state_n    = ST_ERROR;
      es_n       = sensors;
      hold_load  = 1'b1;
      base       = credit_q;
      credit_n   = '0;
      sel_n      = '0;
      dispense_n = 1'b0;
    end

    // Any coin not absorbed into credit rides along with this cycle's refund.
    amt          = {1'b0, base} + ((COIN_VALID && !coin_taken) ? (CREDIT_W+1)'(COIN_VAL) : '0);
    change_n     = amt[CREDIT_W] ? '1 : amt[CREDIT_W-1:0];
    change_vld_n = (amt != '0);
    m_n          = (state_n == ST_IDLE) && !vl_n && (es_n == '0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      credit_q     <= '0;
      change_q     <= '0;
      change_vld_q <= 1'b0;
      dispense_q   <= 1'b0;
      vl_q         <= 1'b0;
      es_q         <= '0;
      m_q          <= 1'b1;
    end else begin
      state_q      <= state_n;
      sel_q        <= sel_n;
      credit_q     <= credit_n;
      change_q     <= change_n;
      change_vld_q <= change_vld_n;
      dispense_q   <= dispense_n;
      vl_q         <= vl_n;
      es_q         <= es_n;
      m_q          <= m_n;
    end
  end

  coffee_timer #(.W(PAY_W)) u_pay_timer (
    .clk(CLK), .rst_n(RST_N), .load(pay_load),
    .load_val(PAY_W'(PAY_TIMEOUT - 1)), .done(pay_done)
  );

  coffee_timer #(.W(DISP_W)) u_disp_timer (
    .clk(CLK), .rst_n(RST_N), .load(disp_load),
    .load_val(DISP_W'(DISP_CYCLES - 1)), .done(disp_done)
  );

  coffee_timer #(.W(HOLD_W)) u_hold_timer (
    .clk(CLK), .rst_n(RST_N), .load(hold_load),
    .load_val(HOLD_W'(ERR_HOLD - 1)), .done(hold_done)
  );

  assign {S3, S2, S1, S0} = sel_q;
  assign {ESR, ESP, ESN}  = es_q;
  assign VL         = vl_q;
  assign M          = m_q;
  assign DISPENSE   = dispense_q;
  assign CREDIT     = credit_q;
  assign CHANGE     = change_q;
  assign CHANGE_VLD = change_vld_q;

endmodule

// File: tb/tb_coffee_order_controller.sv
// Directed bench for coffee_order_controller with hand-computed expectations.
module tb_coffee_order_controller;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BTN;
  logic       CANCEL, COIN_VALID;
  logic [3:0] COIN_VAL;
  logic       SR_IN, SP_IN, SN_IN;
  logic       S0, S1, S2, S3, ESR, ESP, ESN, VL, M, DISPENSE, CHANGE_VLD;
  logic [4:0] CREDIT, CHANGE;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  coffee_order_controller dut (
    .CLK(CLK), .RST_N(RST_N), .BTN(BTN), .CANCEL(CANCEL),
    .COIN_VALID(COIN_VALID), .COIN_VAL(COIN_VAL),
    .SR_IN(SR_IN), .SP_IN(SP_IN), .SN_IN(SN_IN),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3),
    .ESR(ESR), .ESP(ESP), .ESN(ESN), .VL(VL), .M(M),
    .DISPENSE(DISPENSE), .CREDIT(CREDIT), .CHANGE(CHANGE), .CHANGE_VLD(CHANGE_VLD)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    BTN = b;
    tick();
    BTN = 4'd0;
  endtask

  task automatic coin(input int v);
    COIN_VALID = 1'b1;
    COIN_VAL   = 4'(v);
    tick();
    COIN_VALID = 1'b0;
    COIN_VAL   = 4'd0;
  endtask

  // Counts consecutive DISPENSE-high cycles starting at the current one.
  task automatic count_dispense(output int n);
    int guard;
    n = int'(DISPENSE);
    guard = 0;
    while (DISPENSE && guard < 30) begin
      tick();
      guard++;
      if (DISPENSE) n++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    RST_N = 1'b0; BTN = 4'd0; CANCEL = 1'b0; COIN_VALID = 1'b0; COIN_VAL = 4'd0;
    SR_IN = 1'b0; SP_IN = 1'b0; SN_IN = 1'b0;
    tick(); tick();
    check("rst_m", int'(M), 1);
    check("rst_credit", int'(CREDIT), 0);
    check("rst_outs", int'({S3, S2, S1, S0, ESR, ESP, ESN, VL, DISPENSE, CHANGE_VLD}), 0);
    RST_N = 1'b1;
    tick();

    // Two buttons at once are ignored.
    press(4'b0011);
    check("multi_btn_sel", int'({S3, S2, S1, S0}), 0);
    check("multi_btn_m", int'(M), 1);

    // Coin in IDLE comes straight back.
    coin(5);
    check("idle_coin_vld", int'(CHANGE_VLD), 1);
    check("idle_coin_chg", int'(CHANGE), 5);
    check("idle_coin_credit", int'(CREDIT), 0);
    tick();

    // CC05 paid exactly with 2,2,1.
    press(4'b0100);
    check("cc05_s2", int'(S2), 1);
    check("cc05_m", int'(M), 0);
    coin(2); check("cc05_credit2", int'(CREDIT), 2);
    coin(2); check("cc05_credit4", int'(CREDIT), 4);
    coin(1); check("cc05_credit5", int'(CREDIT), 5);
    count_dispense(n);
    check("cc05_disp_len", n, 8);
    check("cc05_no_zero_chg", int'(CHANGE_VLD), 0);
    tick();
    check("cc05_idle_m", int'(M), 1);
    check("cc05_idle_sel", int'({S3, S2, S1, S0}), 0);
    check("cc05_idle_credit", int'(CREDIT), 0);

    // CE01 paid with 10: change 9 right after dispense.
    press(4'b0001);
    coin(10);
    check("ce01_credit", int'(CREDIT), 10);
    count_dispense(n);
    check("ce01_disp_len", n, 8);
    check("ce01_chg_vld", int'(CHANGE_VLD), 1);
    check("ce01_chg", int'(CHANGE), 9);
    tick();
    check("ce01_idle_m", int'(M), 1);

    // CP10 with an illegal coin: refund at once, VL held 16 cycles.
    press(4'b1000);
    coin(3);
    check("ill_vl", int'(VL), 1);
    check("ill_chg_vld", int'(CHANGE_VLD), 1);
    check("ill_chg", int'(CHANGE), 3);
    check("ill_credit", int'(CREDIT), 0);
    n = 1;
    for (int i = 0; i < 30 && VL; i++) begin
      tick();
      if (VL) n++;
    end
    check("ill_vl_len", n, 16);
    CANCEL = 1'b1; tick(); CANCEL = 1'b0;
    check("cancel_zero_no_vld", int'(CHANGE_VLD), 0);
    tick();
    check("cancel_idle_m", int'(M), 1);

    // CL02, one coin, then idle until timeout.
    press(4'b0010);
    coin(1);
    check("to_credit", int'(CREDIT), 1);
    n = 0;
    while (!CHANGE_VLD && n < 100) begin
      tick();
      n++;
    end
    check("to_latency", n, 64);
    check("to_chg", int'(CHANGE), 1);
    check("to_vl", int'(VL), 1);
    tick();
    check("to_idle_sel", int'(S1), 0);
    check("to_idle_credit", int'(CREDIT), 0);
    for (int i = 0; i < 40 && VL; i++) tick();
    check("to_vl_cleared_m", int'(M), 1);

    // CP10, coin 5, pump fault with a simultaneous cancel.
    press(4'b1000);
    coin(5);
    SP_IN = 1'b1; CANCEL = 1'b1;
    tick();
    CANCEL = 1'b0;
    check("sp_esp", int'(ESP), 1);
    check("sp_chg_vld", int'(CHANGE_VLD), 1);
    check("sp_chg", int'(CHANGE), 5);
    check("sp_m", int'(M), 0);
    for (int i = 0; i < 39; i++) tick();
    check("sp_esp_held", int'(ESP), 1);
    SP_IN = 1'b0;
    tick();
    check("sp_exit_esp", int'(ESP), 0);
    check("sp_exit_m", int'(M), 1);

    // Fault present at selection time: ERROR held exactly ERR_HOLD cycles.
    SN_IN = 1'b1;
    press(4'b0001);
    SN_IN = 1'b0;
    check("sel_fault_esn", int'(ESN), 1);
    check("sel_fault_s0", int'(S0), 0);
    n = 1;
    for (int i = 0; i < 40 && ESN; i++) begin
      tick();
      if (ESN) n++;
    end
    check("sel_fault_len", n, 16);
    check("sel_fault_m", int'(M), 1);

    // Coin during dispense is refunded; reset mid-dispense discards credit.
    press(4'b0001);
    coin(2);
    check("rd_disp", int'(DISPENSE), 1);
    coin(5);
    check("rd_coin_vld", int'(CHANGE_VLD), 1);
    check("rd_coin_chg", int'(CHANGE), 5);
    check("rd_credit", int'(CREDIT), 2);
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check("rd_rst_disp", int'(DISPENSE), 0);
    check("rd_rst_credit", int'(CREDIT), 0);
    check("rd_rst_m", int'(M), 1);
    pulses = int'(CHANGE_VLD);
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(CHANGE_VLD);
    end
    check("rd_rst_no_refund", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
